ihp_sram_port_arbiter: RTL and testbench
========================================

Name: ihp_sram_port_arbiter

Overview:
- Shares one single-port IHP SRAM macro (1P, ADDR_WIDTH x DATA_WIDTH, bit-mask writes) between two fabric-side requesters, A and B.
- Each requester enters through its own tile-edge port bundle.
- After reset, optionally sweeps the macro to zero before granting any traffic.
- Provides registered macro drive, round-robin or fixed-priority arbitration, and read-return routing to the owning requester.

Parameters:
- ADDR_WIDTH, 10, macro word-address width (depth = 2**ADDR_WIDTH).
- DATA_WIDTH, 32, word and bit-mask width.
- INIT_ZERO, 1, 1 = zero-fill the whole macro after reset; 0 = skip.
- FIXED_PRIORITY, 0, 1 = A always wins a conflict; 0 = round-robin.

Ports:
- UserCLK  in  1  the only clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high.
- a_req  in  1  requester A command valid; held with fields until a_gnt.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  word address.
- a_wdata  in  DATA_WIDTH  write data.
- a_bm  in  DATA_WIDTH  write bit mask, 1 = write the bit.
- a_gnt  out  1  combinational accept; the command transfers on a cycle with a_req & a_gnt.
- a_rvalid  out  1  read data valid pulse for A.
- a_rdata  out  DATA_WIDTH  read data for A.
- b_req, b_we, b_addr, b_wdata, b_bm, b_gnt, b_rvalid, b_rdata  same as A, for requester B.
- sram_men  out  1  macro enable.
- sram_wen  out  1  macro write enable.
- sram_ren  out  1  macro read enable.
- sram_addr  out  ADDR_WIDTH  macro address.
- sram_din  out  DATA_WIDTH  macro write data.
- sram_bm  out  DATA_WIDTH  macro bit mask.
- sram_dout  in  DATA_WIDTH  macro read data, valid the cycle after a read is sampled.
- init_done  out  1  high once the arbiter accepts traffic.

Behaviour:
- Reset values:
  - All sram_* outputs 0.
  - a_gnt, b_gnt, a_rvalid, b_rvalid 0; a_rdata and b_rdata 0.
  - init_done 0; round-robin pointer = A (A wins the first conflict).
  - The read-return pipeline is cleared. In-flight reads at reset are dropped and no rvalid is produced for them.
  - Reset mid-INIT restarts the sweep from address 0.
- FSM states:
  - INIT: entered from reset when INIT_ZERO=1.
    - Each cycle, registered outputs drive men=1, wen=1, ren=0, addr=counter, din=0, bm=all ones.
    - Counter runs 0..2**ADDR_WIDTH-1.
    - a_gnt and b_gnt are forced 0 regardless of req.
    - After the cycle driving the last address, go to RUN.
  - RUN: entered directly from reset when INIT_ZERO=0.
    - init_done=1 in RUN only, registered. It is first high the cycle after INIT ends, or the first cycle after reset release when INIT_ZERO=0.
- Arbitration (RUN, cycle T, combinational):
  - One requester active: it is granted.
  - Both active, FIXED_PRIORITY=1: A is granted.
  - Both active, FIXED_PRIORITY=0: the requester not granted most recently is granted. The pointer updates only on an actual grant.
  - Never both gnt in one cycle; gnt is never high without the matching req.
  - Full throughput: one grant per cycle, back-to-back, with no idle cycle between commands.
- Command stage (T+1):
  - Granted fields are registered onto the macro: men=1, wen=we, ren=~we, addr, din=wdata, bm=bm.
  - For reads, din and bm are driven 0.
  - On cycles with no grant, men=wen=ren=0 and addr/din/bm hold their last values.
- Read return:
  - An owner tag is pipelined with each read.
  - Owner rvalid is high at T+2 for exactly one cycle.
  - rdata = sram_dout that cycle. rdata is registered-through so it is stable while rvalid is high; it holds its value otherwise.
  - The non-owner's rvalid stays 0.
  - Read latency = 2 cycles from grant.
  - Writes produce no response.
- Ordering: responses return in grant order. A read granted the cycle after a write to the same address returns the new data, since the macro serialises the two commands.
- Width rules: addresses are used unmodified; no wrap logic is needed beyond the natural ADDR_WIDTH width of the INIT counter.

Test Plan:
- INIT_ZERO=1, ADDR_WIDTH=4:
  - Release reset, hold a_req=1 -> exactly 16 consecutive zero writes, addr 0..15, bm=all ones.
  - a_gnt=0 throughout the sweep; init_done rises the cycle after addr 15.
  - The first a_gnt follows.
- Write then read:
  - A writes 0xDEADBEEF to addr 5 with full mask, then reads addr 5 on the next cycle -> a_rvalid at grant+2 with a_rdata=0xDEADBEEF; b_rvalid stays 0.
- Bit-mask write:
  - Write 0xFFFFFFFF with mask 0x0000FFFF over a zeroed word, then read -> 0x0000FFFF.
- Round-robin (FIXED_PRIORITY=0):
  - a_req=b_req=1 held for 6 cycles -> grants alternate A,B,A,B,A,B.
  - Reads are returned to the correct owners in order.
- Fixed priority (FIXED_PRIORITY=1):
  - Both requesting for 4 cycles -> A granted all 4; B granted the cycle A drops req.
- Reset mid-flight:
  - Assert reset the cycle after a read grant -> no rvalid is ever produced for it.
  - All outputs are 0 the cycle after reset; INIT restarts at addr 0.

Source files
------------

// File: rtl/ihp_sram_port_arbiter.sv
// ihp_sram_port_arbiter: two requesters sharing one single-port IHP SRAM macro, with optional zero-fill after reset
module ihp_sram_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter bit INIT_ZERO = 1'b1,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                  UserCLK,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [DATA_WIDTH-1:0] a_bm,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [DATA_WIDTH-1:0] b_bm,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  sram_men,
  output logic                  sram_wen,
  output logic                  sram_ren,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic [DATA_WIDTH-1:0] sram_bm,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  init_done
);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  logic [0:0] state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic prio_b, a_win, any_gnt, sel_we;
  logic rv1, own1, rv2, own2;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata, sel_bm, a_hold, b_hold;
  // A takes the slot when alone, under fixed priority, or when it is A's round-robin turn
  assign a_win     = a_req & (~b_req | FIXED_PRIORITY | ~prio_b);
  assign a_gnt     = init_done & a_win;
  assign b_gnt     = init_done & b_req & ~a_win;
  assign any_gnt   = a_gnt | b_gnt;
  assign sel_we    = a_gnt ? a_we : b_we;
  assign sel_addr  = a_gnt ? a_addr : b_addr;
  assign sel_wdata = a_gnt ? a_wdata : b_wdata;
  assign sel_bm    = a_gnt ? a_bm : b_bm;
  // read data passes straight through while valid, then is held for the owner
  assign a_rvalid  = rv2 & ~own2;
  assign b_rvalid  = rv2 & own2;
  assign a_rdata   = a_rvalid ? sram_dout : a_hold;
  assign b_rdata   = b_rvalid ? sram_dout : b_hold;
  // sweep counter, run state and round-robin pointer (prio_b set = B wins the next conflict)
  always_ff @(posedge UserCLK)
    if (reset) begin
      state     <= INIT_ZERO ? S_INIT : S_RUN;
      cnt       <= '0;
      init_done <= 1'b0;
      prio_b    <= 1'b0;
    end else begin
      if (state == S_INIT) begin
        cnt <= cnt + 1'b1;
        if (&cnt) state <= S_RUN;
      end
      init_done <= state == S_RUN;
      prio_b    <= a_gnt ? 1'b1 : b_gnt ? 1'b0 : prio_b;
    end
  // registered macro drive: zero-fill during the sweep, granted command afterwards
  always_ff @(posedge UserCLK)
    if (reset) begin
      sram_men  <= 1'b0;
      sram_wen  <= 1'b0;
      sram_ren  <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      sram_bm   <= '0;
    end else if (state == S_INIT) begin
      sram_men  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_ren  <= 1'b0;
      sram_addr <= cnt;
      sram_din  <= '0;
      sram_bm   <= '1;
    end else begin
      sram_men <= any_gnt;
      sram_wen <= any_gnt & sel_we;
      sram_ren <= any_gnt & ~sel_we;
      if (any_gnt) begin
        sram_addr <= sel_addr;
        sram_din  <= sel_we ? sel_wdata : '0;
        sram_bm   <= sel_we ? sel_bm : '0;
      end
    end
  // owner tag follows each read through the macro's one-cycle latency
  always_ff @(posedge UserCLK)
    if (reset) begin
      rv1    <= 1'b0;
      own1   <= 1'b0;
      rv2    <= 1'b0;
      own2   <= 1'b0;
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      rv1    <= any_gnt & ~sel_we;
      own1   <= b_gnt;
      rv2    <= rv1;
      own2   <= own1;
      a_hold <= a_rdata;
      b_hold <= b_rdata;
    end
endmodule

// File: tb/tb_ihp_sram_port_arbiter.sv
// tb_ihp_sram_port_arbiter: randomized scoreboard bench for the two-port SRAM arbiter
module tb_ihp_sram_port_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] bm;
  } cmd_t;

  typedef struct packed {
    logic          own;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  logic UserCLK = 1'b0;
  logic reset;
  logic a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, a_bm, b_wdata, b_bm;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, init_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic sram_men, sram_wen, sram_ren;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_bm, sram_dout;

  logic fp_a_gnt, fp_b_gnt, fp_a_rvalid, fp_b_rvalid, fp_init_done;
  logic [DW-1:0] fp_a_rdata, fp_b_rdata;
  logic fp_men, fp_wen, fp_ren;
  logic [AW-1:0] fp_addr;
  logic [DW-1:0] fp_din, fp_bm, fp_dout;

  int n_chk = 0;
  int n_fail = 0;

  always #5 UserCLK = ~UserCLK;

  ihp_sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ZERO(1'b1), .FIXED_PRIORITY(1'b0)) dut (
    .UserCLK(UserCLK), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_bm(a_bm),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_bm(b_bm),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_men(sram_men), .sram_wen(sram_wen), .sram_ren(sram_ren), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_bm(sram_bm), .sram_dout(sram_dout), .init_done(init_done)
  );

  ihp_sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ZERO(1'b0), .FIXED_PRIORITY(1'b1)) dut_fp (
    .UserCLK(UserCLK), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_bm(a_bm),
    .a_gnt(fp_a_gnt), .a_rvalid(fp_a_rvalid), .a_rdata(fp_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_bm(b_bm),
    .b_gnt(fp_b_gnt), .b_rvalid(fp_b_rvalid), .b_rdata(fp_b_rdata),
    .sram_men(fp_men), .sram_wen(fp_wen), .sram_ren(fp_ren), .sram_addr(fp_addr),
    .sram_din(fp_din), .sram_bm(fp_bm), .sram_dout(fp_dout), .init_done(fp_init_done)
  );

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural single-port macro, power-up contents are garbage
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    forever begin
      @(posedge UserCLK);
      if (sram_men && sram_wen) mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
      if (sram_men && sram_ren) sram_dout <= mem[sram_addr];
    end
  end

  int rel_cyc = 0;
  logic rst_q, a_fire, b_fire;
  always @(posedge UserCLK) begin
    rst_q   <= reset;
    rel_cyc <= reset ? 0 : rel_cyc + 1;
    a_fire  <= a_req & a_gnt;
    b_fire  <= b_req & b_gnt;
  end

  // reference model and monitor
  logic [DW-1:0] ref_mem [DEPTH];
  logic last_b = 1'b1;
  logic pend = 1'b0;
  cmd_t pc;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_din, l_bm;
  rsp_t sb[$];

  always @(negedge UserCLK) begin
    logic ea, eb, ei;
    cmd_t c;
    rsp_t r;
    if (rst_q) begin
      check("reset_sram", {sram_men, sram_wen, sram_ren, sram_addr, sram_din, sram_bm}, '0);
      check("reset_ports", {init_done, a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata}, '0);
      check("fp_reset", {fp_men, fp_init_done, fp_a_gnt, fp_b_gnt, fp_a_rvalid, fp_b_rvalid, fp_addr, fp_din}, '0);
      sb.delete();
      pend = 1'b0;
      last_b = 1'b1;
      l_addr = '0;
      l_din = '0;
      l_bm = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      ei = rel_cyc > DEPTH;
      check("init_done", init_done, ei);
      if (rel_cyc <= DEPTH) begin
        check("sweep_bus", {sram_men, sram_wen, sram_ren, sram_addr, sram_din, sram_bm},
              {3'b110, AW'(rel_cyc - 1), {DW{1'b0}}, {DW{1'b1}}});
        l_addr = AW'(rel_cyc - 1);
        l_din = '0;
        l_bm = '1;
      end else if (pend) begin
        check("cmd_bus", {sram_men, sram_wen, sram_ren, sram_addr, sram_din, sram_bm},
              {1'b1, pc.we, !pc.we, pc.addr, pc.we ? pc.wdata : {DW{1'b0}}, pc.we ? pc.bm : {DW{1'b0}}});
        l_addr = pc.addr;
        l_din = pc.we ? pc.wdata : '0;
        l_bm = pc.we ? pc.bm : '0;
      end else
        check("idle_bus", {sram_men, sram_wen, sram_ren, sram_addr, sram_din, sram_bm}, {3'b000, l_addr, l_din, l_bm});
      if (a_rvalid || b_rvalid) begin
        if (sb.size() == 0) check("unexpected_rvalid", {a_rvalid, b_rvalid}, 2'b00);
        else begin
          r = sb.pop_front();
          check("rsp_owner", {a_rvalid, b_rvalid}, r.own ? 2'b01 : 2'b10);
          check("rsp_cycle", rel_cyc, r.due);
          check("rsp_data", b_rvalid ? b_rdata : a_rdata, r.data);
        end
      end else if (sb.size() > 0 && sb[0].due <= rel_cyc) begin
        r = sb.pop_front();
        check("rsp_missing", {a_rvalid, b_rvalid}, r.own ? 2'b01 : 2'b10);
      end
      // both requesting: the one not granted most recently wins
      ea = ei && a_req && (!b_req || last_b);
      eb = ei && b_req && !ea;
      check("grants", {a_gnt, b_gnt}, {ea, eb});
      check("fp_grants", {fp_init_done, fp_a_gnt, fp_b_gnt}, {1'b1, a_req, b_req && !a_req});
      pend = 1'b0;
      if (!reset && (ea || eb)) begin
        c = ea ? cmd_t'{a_we, a_addr, a_wdata, a_bm} : cmd_t'{b_we, b_addr, b_wdata, b_bm};
        pend = 1'b1;
        pc = c;
        last_b = eb;
        if (c.we) ref_mem[c.addr] = (ref_mem[c.addr] & ~c.bm) | (c.wdata & c.bm);
        else sb.push_back(rsp_t'{eb, ref_mem[c.addr], rel_cyc + 2});
      end
    end
  end

  // stimulus: each requester holds its head command until it fires
  cmd_t aq[$], bq[$];

  function automatic cmd_t mk(logic we, logic [AW-1:0] addr, logic [DW-1:0] d, logic [DW-1:0] bm);
    return {we, addr, d, bm};
  endfunction

  function automatic cmd_t rnd();
    return mk(1'(($urandom_range(1))), AW'($urandom_range(DEPTH - 1)), $urandom,
              $urandom_range(1) == 1 ? {DW{1'b1}} : $urandom);
  endfunction

  task automatic apply();
    cmd_t c;
    a_req = aq.size() > 0;
    c = a_req ? aq[0] : '0;
    {a_we, a_addr, a_wdata, a_bm} = c;
    b_req = bq.size() > 0;
    c = b_req ? bq[0] : '0;
    {b_we, b_addr, b_wdata, b_bm} = c;
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
    if (a_fire && aq.size() > 0) void'(aq.pop_front());
    if (b_fire && bq.size() > 0) void'(bq.pop_front());
    apply();
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n && (aq.size() > 0 || bq.size() > 0); i++) tick();
    check("drain_timeout", aq.size() + bq.size(), 0);
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1;
    fp_dout = '0;
    aq.push_back(mk(1'b0, 4'd0, '0, '0));
    apply();
    repeat (3) tick();
    reset = 1'b0;
    drain(40);
    aq.push_back(mk(1'b1, 4'd5, 32'hDEADBEEF, '1));
    aq.push_back(mk(1'b0, 4'd5, '0, '0));
    aq.push_back(mk(1'b1, 4'd7, 32'hFFFFFFFF, 32'h0000FFFF));
    aq.push_back(mk(1'b0, 4'd7, '0, '0));
    drain(20);
    for (int i = 0; i < 3; i++) begin
      aq.push_back(mk(1'b0, AW'(5 + 2 * i), '0, '0));
      bq.push_back(mk(1'b0, AW'(7 - 2 * i), '0, '0));
    end
    drain(20);
    repeat (400) begin
      if (aq.size() < 2 && $urandom_range(3) != 0) aq.push_back(rnd());
      if (bq.size() < 2 && $urandom_range(3) != 0) bq.push_back(rnd());
      tick();
    end
    drain(40);
    aq.push_back(mk(1'b0, 4'd5, '0, '0));
    for (int i = 0; i < 20 && !a_fire; i++) tick();
    check("midflight_grant", a_fire, 1'b1);
    aq.delete();
    bq.delete();
    reset = 1'b1;
    apply();
    repeat (2) tick();
    reset = 1'b0;
    repeat (DEPTH + 4) tick();
    repeat (40) begin
      if (aq.size() < 2 && $urandom_range(1) != 0) aq.push_back(rnd());
      if (bq.size() < 2 && $urandom_range(1) != 0) bq.push_back(rnd());
      tick();
    end
    drain(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
